hazard_control_unit: RTL and testbench
======================================

# hazard_control_unit

Pipeline hazard sequencer for the 5-stage RISC-V core. It sits beside the forwarding logic in the risk-detection group and covers the cases forwarding cannot resolve. It inserts load-use bubbles, flushes wrong-path instructions after a taken branch, and freezes the whole pipeline while the data memory has not acknowledged an access. It drives the write-enables and flush/bubble controls of PC, IF/ID and ID/EX, plus a global hold for the downstream registers.

## Interface
- LOAD_BUBBLES, 1: bubbles inserted per load-use hazard (legal 1..3)
- MEM_TIMEOUT, 255: wait cycles before memory-timeout error flags (legal 1..255)
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset
- mem_read_ex  in  1  instruction in EX is a load
- rd_ex  in  5  destination of instruction in EX
- rs1_id, rs2_id  in  5  source registers of instruction in ID
- opcode_id  in  7  opcode of instruction in ID
- branch_taken_ex  in  1  branch/jump in EX resolved taken
- dmem_req  in  1  MEM stage issuing a data-memory access
- dmem_ready  in  1  data memory accepts/completes access this cycle
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID update enable
- ifid_flush  out  1  load NOP into IF/ID
- idex_bubble  out  1  load NOP (all control zero) into ID/EX
- pipe_hold  out  1  hold ID/EX, EX/MEM, MEM/WB
- mem_timeout_err  out  1  sticky timeout flag
- stall_cycles  out  32  perf counter (see Configuration)
- flush_count  out  32  perf counter (see Configuration)

## Operation
- Source use decode on opcode_id:
  - uses_rs1: 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - uses_rs2: 0110011, 0100011, 1100011.
  - All others use neither.
- Load-use hazard: mem_read_ex && rd_ex!=0 && ((uses_rs1 && rd_ex==rs1_id) || (uses_rs2 && rd_ex==rs2_id)).
- mem_busy = dmem_req && !dmem_ready.
- States: RUN, LOAD_STALL, MEM_WAIT. Registers:
  - bubble counter bcnt (2 bits).
  - return state ret (RUN/LOAD_STALL).
  - wait counter wcnt (8 bits).
- Priority, highest first: mem_busy > branch_taken_ex > load-use.
- Outputs are combinational from state and inputs. Defaults: pc_write=1, ifid_write=1, all others 0.
- mem_busy, any state:
  - Outputs: pc_write=0, ifid_write=0, pipe_hold=1, ifid_flush=0, idex_bubble=0.
  - Entering MEM_WAIT from RUN/LOAD_STALL: ret <= current state, wcnt <= 1.
  - bcnt is frozen.
- MEM_WAIT:
  - While mem_busy: wcnt increments, saturating at 255. When wcnt==MEM_TIMEOUT, mem_timeout_err <= 1, sticky until RST; keep waiting.
  - When !mem_busy: go to ret and evaluate that state's rules in the same cycle.
- RUN:
  - branch_taken_ex: ifid_flush=1, idex_bubble=1; load-use ignored; stay RUN.
  - Else load-use: pc_write=0, ifid_write=0, idex_bubble=1. If LOAD_BUBBLES==1 stay RUN; else bcnt <= LOAD_BUBBLES-1 and go to LOAD_STALL.
- LOAD_STALL:
  - Outputs: pc_write=0, ifid_write=0, idex_bubble=1.
  - bcnt decrements; go to RUN when bcnt reaches 0.
  - branch_taken_ex cannot occur here, because EX holds a bubble.
- RST: state RUN, bcnt=0, wcnt=0, ret=RUN, mem_timeout_err=0, counters=0. This holds even mid-stall or mid-wait.

## Timing
- Reset values of outputs: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, pipe_hold=0, mem_timeout_err=0, stall_cycles=0, flush_count=0.
- Detection is zero latency: controls are asserted in the same cycle the hazard appears in ID/EX and take effect at the next rising edge.
- A load-use hazard costs exactly LOAD_BUBBLES cycles. A taken branch costs 2 flushed slots.
- Memory freeze covers every cycle mem_busy is 1. Release happens in the cycle dmem_ready rises.
- A branch arriving in EX during a freeze is held with EX. It is acted on in the first non-busy cycle.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cycles increments (wrapping) each cycle pc_write==0.
  - flush_count increments (wrapping) each cycle ifid_flush==1.
- HAZARD_PERF_CNT_EN undefined: both ports are present and tied to 0, and no counter registers exist.

## Test plan
- lw x5 in EX (mem_read_ex=1, rd_ex=5), add in ID with rs2_id=5, opcode 0110011, LOAD_BUBBLES=1 -> one cycle with pc_write=0, ifid_write=0, idex_bubble=1; next cycle all defaults.
- Same hazard with rd_ex=0, or with addi (0010011) matching only rs2_id -> no stall.
- branch_taken_ex=1 together with a load-use hazard -> ifid_flush=1 and idex_bubble=1, pc_write=1, for one cycle; flush_count +1.
- LOAD_BUBBLES=3, hazard, then dmem_req=1/dmem_ready=0 for 4 cycles during the 2nd bubble:
  - pipe_hold=1 for those 4 cycles.
  - 3 bubbles are still inserted.
  - stall_cycles = 7.
- MEM_TIMEOUT=4, dmem_ready held 0 for 6 cycles -> mem_timeout_err rises after the 4th wait cycle and stays 1 after release, until RST.
- RST asserted mid-LOAD_STALL and mid-MEM_WAIT -> next cycle all outputs at reset values, state RUN.

Source files
------------

// File: rtl/hazard_control_unit_if.sv
// Hazard-unit signal bundle: ID/EX hazard sources and memory handshake in,
// pipeline register controls and status out.
interface hazard_control_unit_if;
    logic        mem_read_ex;
    logic [4:0]  rd_ex;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic [6:0]  opcode_id;
    logic        branch_taken_ex;
    logic        dmem_req;
    logic        dmem_ready;

    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        pipe_hold;
    logic        mem_timeout_err;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    modport master (
        output mem_read_ex, rd_ex, rs1_id, rs2_id, opcode_id,
               branch_taken_ex, dmem_req, dmem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold,
               mem_timeout_err, stall_cycles, flush_count
    );

    modport slave (
        input  mem_read_ex, rd_ex, rs1_id, rs2_id, opcode_id,
               branch_taken_ex, dmem_req, dmem_ready,
        output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold,
               mem_timeout_err, stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Load-use bubbles, taken-branch flush and data-memory freeze sequencer.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
module hazard_control_unit #(
    parameter int unsigned LOAD_BUBBLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 255
) (
    input  logic                 CLK,
    input  logic                 RST,
    hazard_control_unit_if.slave hz
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_t;

    localparam logic [1:0] BUBBLES_M1 = 2'(LOAD_BUBBLES - 1);
    localparam logic [7:0] TIMEOUT    = 8'(MEM_TIMEOUT);

    state_t     state, state_n, ret, ret_n, eff;
    logic [1:0] bcnt, bcnt_n;
    logic [7:0] wcnt, wcnt_n;
    logic       err, err_n;

    logic uses_rs1, uses_rs2, load_use, mem_busy;
    logic pc_write_c, ifid_write_c, ifid_flush_c, idex_bubble_c, pipe_hold_c;

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (hz.opcode_id)
            7'b0110011, 7'b0100011, 7'b1100011: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111: uses_rs1 = 1'b1;
            default: ;
        endcase
    end

    assign load_use = hz.mem_read_ex && (hz.rd_ex != 5'd0) &&
                      ((uses_rs1 && (hz.rd_ex == hz.rs1_id)) ||
                       (uses_rs2 && (hz.rd_ex == hz.rs2_id)));
    assign mem_busy = hz.dmem_req && !hz.dmem_ready;

    always_comb begin
        pc_write_c    = 1'b1;
        ifid_write_c  = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_bubble_c = 1'b0;
        pipe_hold_c   = 1'b0;
        state_n       = state;
        ret_n         = ret;
        bcnt_n        = bcnt;
        wcnt_n        = wcnt;
        err_n         = err;
        // On release from MEM_WAIT the saved state's rules apply in the same cycle.
        eff           = (state == MEM_WAIT) ? ret : state;

        if (mem_busy) begin
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
            pipe_hold_c  = 1'b1;
            if (state == MEM_WAIT) begin
                wcnt_n = (wcnt == 8'hFF) ? wcnt : wcnt + 8'd1;
                if (wcnt == TIMEOUT)
                    err_n = 1'b1;
            end else begin
                ret_n   = state;
                wcnt_n  = 8'd1;
                state_n = MEM_WAIT;
            end
        end else begin
            state_n = eff;
            case (eff)
                LOAD_STALL: begin
                    pc_write_c    = 1'b0;
                    ifid_write_c  = 1'b0;
                    idex_bubble_c = 1'b1;
                    bcnt_n        = bcnt - 2'd1;
                    if (bcnt <= 2'd1)
                        state_n = RUN;
                end
                default: begin
                    if (hz.branch_taken_ex) begin
                        ifid_flush_c  = 1'b1;
                        idex_bubble_c = 1'b1;
                    end else if (load_use) begin
                        pc_write_c    = 1'b0;
                        ifid_write_c  = 1'b0;
                        idex_bubble_c = 1'b1;
                        if (LOAD_BUBBLES > 1) begin
                            bcnt_n  = BUBBLES_M1;
                            state_n = LOAD_STALL;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RUN;
            ret   <= RUN;
            bcnt  <= '0;
            wcnt  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            ret   <= ret_n;
            bcnt  <= bcnt_n;
            wcnt  <= wcnt_n;
            err   <= err_n;
        end
    end

    assign hz.pc_write        = pc_write_c;
    assign hz.ifid_write      = ifid_write_c;
    assign hz.ifid_flush      = ifid_flush_c;
    assign hz.idex_bubble     = idex_bubble_c;
    assign hz.pipe_hold       = pipe_hold_c;
    assign hz.mem_timeout_err = err;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_write_c)
                stall_q <= stall_q + 32'd1;
            if (ifid_flush_c)
                flush_q <= flush_q + 32'd1;
        end
    end

    assign hz.stall_cycles = stall_q;
    assign hz.flush_count  = flush_q;
`else
    assign hz.stall_cycles = '0;
    assign hz.flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: two instances (1 bubble / timeout 4,
// and 3 bubbles / timeout 255) driven with directed per-cycle vectors.
module tb_hazard_control_unit;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // ctl = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, mem_timeout_err}
    localparam logic [5:0] DEF  = 6'b110000;
    localparam logic [5:0] STL  = 6'b000100;
    localparam logic [5:0] BR   = 6'b111100;
    localparam logic [5:0] HOLD = 6'b000010;
    localparam logic [5:0] ERR  = 6'b000001;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_LU = 7'b0110111;

    typedef struct {
        bit          sel;
        logic [5:0]  ctl;
        bit          chk;
        int unsigned st;
        int unsigned fl;
        string       name;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    exp_t exp_q[$];

    hazard_control_unit_if ifa ();
    hazard_control_unit_if ifb ();

    hazard_control_unit #(.LOAD_BUBBLES(1), .MEM_TIMEOUT(4)) dut_a (
        .CLK(CLK), .RST(RST), .hz(ifa)
    );
    hazard_control_unit #(.LOAD_BUBBLES(3), .MEM_TIMEOUT(255)) dut_b (
        .CLK(CLK), .RST(RST), .hz(ifb)
    );

    always #5 CLK = ~CLK;

    function automatic int unsigned pv(input int unsigned n);
        return PERF ? n : 0;
    endfunction

    task automatic set_in(input bit sel, input logic mre, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [6:0] op, input logic br,
                          input logic req, input logic rdy);
        ifa.mem_read_ex = 1'b0; ifa.rd_ex = '0; ifa.rs1_id = '0; ifa.rs2_id = '0;
        ifa.opcode_id = '0; ifa.branch_taken_ex = 1'b0; ifa.dmem_req = 1'b0; ifa.dmem_ready = 1'b1;
        ifb.mem_read_ex = 1'b0; ifb.rd_ex = '0; ifb.rs1_id = '0; ifb.rs2_id = '0;
        ifb.opcode_id = '0; ifb.branch_taken_ex = 1'b0; ifb.dmem_req = 1'b0; ifb.dmem_ready = 1'b1;
        if (!sel) begin
            ifa.mem_read_ex = mre; ifa.rd_ex = rd; ifa.rs1_id = rs1; ifa.rs2_id = rs2;
            ifa.opcode_id = op; ifa.branch_taken_ex = br; ifa.dmem_req = req; ifa.dmem_ready = rdy;
        end else begin
            ifb.mem_read_ex = mre; ifb.rd_ex = rd; ifb.rs1_id = rs1; ifb.rs2_id = rs2;
            ifb.opcode_id = op; ifb.branch_taken_ex = br; ifb.dmem_req = req; ifb.dmem_ready = rdy;
        end
    endtask

    task automatic cyc(input bit sel, input logic mre, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [6:0] op, input logic br, input logic req,
                       input logic rdy, input logic [5:0] ctl, input string nm,
                       input bit chk = 1'b0, input int unsigned st = 0,
                       input int unsigned fl = 0);
        exp_t e;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        set_in(sel, mre, rd, rs1, rs2, op, br, req, rdy);
        e.sel = sel; e.ctl = ctl; e.chk = chk; e.st = st; e.fl = fl; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic idle(input bit sel, input logic [5:0] ctl, input string nm,
                        input bit chk = 1'b0, input int unsigned st = 0,
                        input int unsigned fl = 0);
        cyc(sel, 1'b0, 5'd0, 5'd0, 5'd0, 7'd0, 1'b0, 1'b0, 1'b1, ctl, nm, chk, st, fl);
    endtask

    task automatic pulse_reset();
        @(posedge CLK);
        #1;
        RST = 1'b1;
        set_in(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 7'd0, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: outputs are combinational and valid every cycle, so one entry per cycle.
    always @(negedge CLK) begin : monitor
        exp_t        e;
        logic [5:0]  got;
        logic [31:0] gs, gf;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (!e.sel) begin
                got = {ifa.pc_write, ifa.ifid_write, ifa.ifid_flush, ifa.idex_bubble,
                       ifa.pipe_hold, ifa.mem_timeout_err};
                gs = ifa.stall_cycles; gf = ifa.flush_count;
            end else begin
                got = {ifb.pc_write, ifb.ifid_write, ifb.ifid_flush, ifb.idex_bubble,
                       ifb.pipe_hold, ifb.mem_timeout_err};
                gs = ifb.stall_cycles; gf = ifb.flush_count;
            end
            n_cmp++;
            if (got !== e.ctl) begin
                n_bad++;
                $display("FAIL %s: ctl got=%b expected=%b", e.name, got, e.ctl);
            end
            if (e.chk) begin
                n_cmp++;
                if (gs !== e.st) begin
                    n_bad++;
                    $display("FAIL %s.stall_cycles: got=%0d expected=%0d", e.name, gs, e.st);
                end
                n_cmp++;
                if (gf !== e.fl) begin
                    n_bad++;
                    $display("FAIL %s.flush_count: got=%0d expected=%0d", e.name, gf, e.fl);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        set_in(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 7'd0, 1'b0, 1'b0, 1'b1);
        pulse_reset();
        idle(0, DEF, "a_reset", 1, 0, 0);
        idle(1, DEF, "b_reset", 1, 0, 0);

        // Instance A: single bubble, timeout 4
        cyc(0, 1, 5'd5, 5'd0, 5'd5, OP_R,  0, 0, 1, STL, "a_lu_add_rs2");
        idle(0, DEF, "a_lu_after");
        cyc(0, 1, 5'd0, 5'd0, 5'd0, OP_R,  0, 0, 1, DEF, "a_rd0");
        cyc(0, 1, 5'd5, 5'd3, 5'd5, OP_I,  0, 0, 1, DEF, "a_addi_rs2_only");
        cyc(0, 1, 5'd5, 5'd5, 5'd5, OP_LU, 0, 0, 1, DEF, "a_lui_no_src");
        cyc(0, 1, 5'd9, 5'd1, 5'd9, OP_ST, 0, 0, 1, STL, "a_sw_rs2");
        cyc(0, 1, 5'd9, 5'd9, 5'd0, OP_LD, 0, 0, 1, STL, "a_lw_rs1");
        cyc(0, 0, 5'd9, 5'd9, 5'd0, OP_R,  0, 0, 1, DEF, "a_no_load");
        cyc(0, 1, 5'd5, 5'd0, 5'd5, OP_R,  1, 0, 1, BR,  "a_branch_over_lu");
        idle(0, DEF, "a_branch_after", 1, pv(3), pv(1));

        for (int i = 1; i <= 5; i++)
            cyc(0, 0, 5'd0, 5'd0, 5'd0, 7'd0, 0, 1, 0, HOLD, $sformatf("a_busy%0d", i));
        cyc(0, 0, 5'd0, 5'd0, 5'd0, 7'd0, 1, 1, 0, HOLD | ERR, "a_busy6_timeout");
        cyc(0, 0, 5'd0, 5'd0, 5'd0, 7'd0, 1, 1, 1, BR | ERR, "a_release_branch");
        idle(0, DEF | ERR, "a_err_sticky", 1, pv(9), pv(2));
        cyc(0, 0, 5'd0, 5'd0, 5'd0, 7'd0, 0, 1, 0, HOLD | ERR, "a_wait1");
        cyc(0, 0, 5'd0, 5'd0, 5'd0, 7'd0, 0, 1, 0, HOLD | ERR, "a_wait2");
        pulse_reset();
        idle(0, DEF, "a_reset_mid_wait", 1, 0, 0);

        // Instance B: three bubbles with a memory freeze during the second
        cyc(1, 1, 5'd7, 5'd7, 5'd0, OP_LD, 0, 0, 1, STL, "b_lu_bub1");
        for (int i = 1; i <= 4; i++)
            cyc(1, 0, 5'd0, 5'd0, 5'd0, 7'd0, 0, 1, 0, HOLD, $sformatf("b_freeze%0d", i));
        idle(1, STL, "b_bub2");
        idle(1, STL, "b_bub3");
        idle(1, DEF, "b_done", 1, pv(7), 0);
        cyc(1, 1, 5'd4, 5'd0, 5'd4, OP_R, 0, 0, 1, STL, "b_lu2_bub1");
        idle(1, STL, "b_lu2_bub2");
        idle(1, STL, "b_lu2_bub3");
        idle(1, DEF, "b_lu2_done", 1, pv(10), 0);
        cyc(1, 1, 5'd4, 5'd4, 5'd0, OP_I, 0, 0, 1, STL, "b_lu3_bub1");
        idle(1, STL, "b_lu3_bub2");
        pulse_reset();
        idle(1, DEF, "b_reset_mid_stall", 1, 0, 0);
        idle(1, DEF, "b_idle_after_reset");

        repeat (3) @(posedge CLK);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
